// File: rtl/conv_window_streamer_if.sv
// Stream bundle for conv_window_streamer: pixel input and window output.
// master = pixel source / window sink, slave = the streamer itself.
interface conv_window_streamer_if #(
  parameter int DATA_W = 16,
  parameter int K      = 3
);
  logic                     s_axis_valid;
  logic [31:0]              s_axis_data;
  logic                     s_axis_last;
  logic                     s_axis_ready;
  logic                     m_win_valid;
  logic [K*K*DATA_W-1:0]    m_win_data;
  logic                     m_win_ready;
  logic                     m_win_last;

  modport master (
    output s_axis_valid, s_axis_data, s_axis_last, m_win_ready,
    input  s_axis_ready, m_win_valid, m_win_data, m_win_last
  );

  modport slave (
    input  s_axis_valid, s_axis_data, s_axis_last, m_win_ready,
    output s_axis_ready, m_win_valid, m_win_data, m_win_last
  );
endinterface

// File: rtl/conv_window_streamer.sv
// KxK sliding-window generator over a raster pixel stream.
// K-1 line buffers feed a column shift window; one window per valid position.
module conv_window_streamer #(
  parameter int DATA_W    = 16,
  parameter int K         = 3,
  parameter int MAX_WIDTH = 1024,
  parameter int DIM_W     = 11
) (
  input  logic             axi_clk,
  input  logic             axi_reset_n,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic             cfg_start,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             last_err,
  conv_window_streamer_if.slave axis
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int WW = K * K * DATA_W;

  logic [1:0]       state_q, state_d;
  logic [DIM_W-1:0] w_q, h_q, col_q, row_q;
  logic             eof_q, cfg_err_q, last_err_q, done_q;
  logic             vld_q, last_q;
  logic [WW-1:0]    data_q, flat;

  logic [DATA_W-1:0] lb    [K-1][MAX_WIDTH];
  logic [DATA_W-1:0] win_q [K][K];
  logic [DATA_W-1:0] win_d [K][K];

  logic [DATA_W-1:0] pix;
  logic [AW-1:0]     ca;
  logic rdy, acc, col_end, is_final, win_hit, cfg_ok, hs_last;

  generate
    if (DATA_W < 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^axis.s_axis_data[31:DATA_W];
    end
  endgenerate

  assign pix      = axis.s_axis_data[DATA_W-1:0];
  assign ca       = col_q[AW-1:0];
  assign rdy      = (state_q == S_RUN) && !eof_q &&
                    (!vld_q || axis.m_win_ready);
  assign acc      = rdy && axis.s_axis_valid;
  assign col_end  = (col_q == w_q - DIM_W'(1));
  assign is_final = col_end && (row_q == h_q - DIM_W'(1));
  assign win_hit  = (row_q >= DIM_W'(K-1)) && (col_q >= DIM_W'(K-1));
  assign cfg_ok   = (cfg_width >= DIM_W'(K)) &&
                    (cfg_width <= DIM_W'(MAX_WIDTH)) &&
                    (cfg_height >= DIM_W'(K));
  assign hs_last  = vld_q && axis.m_win_ready && last_q;

  assign busy              = (state_q == S_RUN);
  assign done              = done_q;
  assign cfg_err           = cfg_err_q;
  assign last_err          = last_err_q;
  assign axis.s_axis_ready = rdy;
  assign axis.m_win_valid  = vld_q;
  assign axis.m_win_data   = data_q;
  assign axis.m_win_last   = last_q;

  // Shift window left by one column; new column = buffered rows + pixel.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K-1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
    end
    for (int r = 0; r < K-1; r++) begin
      win_d[r][K-1] = lb[r][ca];
    end
    win_d[K-1][K-1] = pix;
  end

  // Flatten the shifted window, row 0 oldest, column 0 leftmost.
  always_comb begin
    flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        flat[(r*K+c)*DATA_W +: DATA_W] = win_d[r][c];
      end
    end
  end

  // Frame sequencing: IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cfg_start && cfg_ok) state_d = S_RUN;
      S_RUN:   if (hs_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Line buffers age one row per write; window storage needs no reset.
  always_ff @(posedge axi_clk) begin
    if (acc) begin
      for (int j = 0; j < K-2; j++) begin
        lb[j][ca] <= lb[j+1][ca];
      end
      lb[K-2][ca] <= pix;
      win_q <= win_d;
    end
  end

  // Control, counters, error flags and the output register.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q    <= S_IDLE;
      w_q        <= '0;
      h_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      eof_q      <= 1'b0;
      cfg_err_q  <= 1'b0;
      last_err_q <= 1'b0;
      done_q     <= 1'b0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == S_DONE);
      if (state_q == S_IDLE && cfg_start) begin
        last_err_q <= 1'b0;
        if (cfg_ok) begin
          w_q       <= cfg_width;
          h_q       <= cfg_height;
          col_q     <= '0;
          row_q     <= '0;
          eof_q     <= 1'b0;
          cfg_err_q <= 1'b0;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end
      if (acc) begin
        col_q <= col_end ? '0 : col_q + DIM_W'(1);
        if (col_end) row_q <= row_q + DIM_W'(1);
        if (is_final) eof_q <= 1'b1;
        if (axis.s_axis_last != is_final) last_err_q <= 1'b1;
      end
      if (acc && win_hit) begin
        vld_q  <= 1'b1;
        last_q <= is_final;
        data_q <= flat;
      end else if (axis.m_win_ready) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_streamer.sv
// Scoreboard bench for conv_window_streamer (K=3/16b and K=5/8b).
// Windows are predicted from a stored image when pixels are driven.
module tb_conv_window_streamer;

  logic clk, rst_n;
  logic [10:0] cw0, ch0;
  logic cs0, busy0, done0, cerr0, lerr0;
  logic [4:0] cw1, ch1;
  logic cs1, busy1, done1, cerr1, lerr1;

  conv_window_streamer_if #(.DATA_W(16), .K(3)) if0 ();
  conv_window_streamer_if #(.DATA_W(8), .K(5)) if1 ();

  conv_window_streamer #(
    .DATA_W(16), .K(3), .MAX_WIDTH(1024), .DIM_W(11)
  ) u0 (
    .axi_clk(clk), .axi_reset_n(rst_n),
    .cfg_width(cw0), .cfg_height(ch0), .cfg_start(cs0),
    .busy(busy0), .done(done0), .cfg_err(cerr0), .last_err(lerr0),
    .axis(if0.slave)
  );

  conv_window_streamer #(
    .DATA_W(8), .K(5), .MAX_WIDTH(16), .DIM_W(5)
  ) u1 (
    .axi_clk(clk), .axi_reset_n(rst_n),
    .cfg_width(cw1), .cfg_height(ch1), .cfg_start(cs1),
    .busy(busy1), .done(done1), .cfg_err(cerr1), .last_err(lerr1),
    .axis(if1.slave)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, rc = 0, acyc = 0, rmode = 0;
  bit [3:0] patt = 4'b1001;
  logic [15:0] img0 [1024];
  logic [7:0]  img1 [256];
  logic [143:0] q0 [$];
  bit ql0 [$];
  logic [199:0] q1 [$];
  bit ql1 [$];

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    rc++;
    if0.m_win_ready = (rmode == 0) ? 1'b1 : patt[rc%4];
  end

  function automatic logic [143:0] win0(input int w, r, c);
    logic [143:0] v;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[(i*3+j)*16 +: 16] = img0[(r-2+i)*w + c-2+j];
    return v;
  endfunction

  function automatic logic [199:0] win1(input int w, r, c);
    logic [199:0] v;
    v = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        v[(i*5+j)*8 +: 8] = img1[(r-4+i)*w + c-4+j];
    return v;
  endfunction

  task automatic cfg0(input int w, h);
    cw0 = 11'(w);
    ch0 = 11'(h);
    cs0 = 1'b1;
    @(posedge clk);
    #1;
    cs0 = 1'b0;
  endtask

  task automatic drive0(input int w, h, n, badlast);
    int r, c, t;
    for (int i = 0; i < n; i++) begin
      r = i / w;
      c = i % w;
      t = 0;
      if0.s_axis_valid = 1'b1;
      if0.s_axis_data  = {16'($urandom), img0[i]};
      if0.s_axis_last  = badlast ? (i == 10) : (i == w*h-1);
      do begin
        @(negedge clk);
        t++;
      end while (!if0.s_axis_ready && t < 100);
      check("in_ready", if0.s_axis_ready, 1);
      if (!if0.s_axis_ready) begin
        if0.s_axis_valid = 1'b0;
        return;
      end
      if (r >= 2 && c >= 2) begin
        q0.push_back(win0(w, r, c));
        ql0.push_back(i == w*h-1);
        if (r == 2 && c == 2) acyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    if0.s_axis_valid = 1'b0;
    if0.s_axis_last  = 1'b0;
  endtask

  task automatic mon0(input int nexp);
    int got, t;
    bit fin, pv, seen;
    logic [143:0] pd, e;
    bit el;
    got = 0; t = 0; fin = 0; pv = 0; seen = 0;
    while (!fin && t < 3000) begin
      @(negedge clk);
      t++;
      if (pv) check("stall_hold", if0.m_win_data, pd);
      pv = 0;
      if (if0.m_win_valid) begin
        if (!seen) begin
          seen = 1;
          check("first_lat", cyc - acyc, 1);
        end
        if (if0.m_win_ready) begin
          check("sb_level", q0.size() > 0, 1);
          if (q0.size() > 0) begin
            e  = q0.pop_front();
            el = ql0.pop_front();
            check("win_data", if0.m_win_data, e);
            check("win_last", if0.m_win_last, el);
          end
          got++;
          fin = if0.m_win_last;
        end else begin
          check("stall_rdy", if0.s_axis_ready, 0);
          pd = if0.m_win_data;
          pv = 1;
        end
      end
    end
    check("win_count", got, nexp);
    check("sb_drain", q0.size(), 0);
    @(negedge clk);
    check("done_hi", done0, 1);
    check("busy_lo", busy0, 0);
    @(negedge clk);
    check("done_lo", done0, 0);
  endtask

  task automatic run0(input int w, h, rm, badlast, rnd);
    for (int i = 0; i < w*h; i++)
      img0[i] = rnd ? 16'($urandom) : 16'(i);
    rmode = rm;
    cfg0(w, h);
    check("busy_run", busy0, 1);
    check("cfg_err_clr", cerr0, 0);
    fork
      drive0(w, h, w*h, badlast);
      mon0((w-2)*(h-2));
    join
    check("last_err", lerr0, badlast);
    rmode = 0;
  endtask

  task automatic drive1(input int w, n);
    int r, c, t;
    for (int i = 0; i < n; i++) begin
      r = i / w;
      c = i % w;
      t = 0;
      if1.s_axis_valid = 1'b1;
      if1.s_axis_data  = {24'($urandom), img1[i]};
      if1.s_axis_last  = (i == n-1);
      do begin
        @(negedge clk);
        t++;
      end while (!if1.s_axis_ready && t < 100);
      check("k5_in_ready", if1.s_axis_ready, 1);
      if (!if1.s_axis_ready) begin
        if1.s_axis_valid = 1'b0;
        return;
      end
      if (r >= 4 && c >= 4) begin
        q1.push_back(win1(w, r, c));
        ql1.push_back(i == n-1);
      end
      @(posedge clk);
      #1;
    end
    if1.s_axis_valid = 1'b0;
    if1.s_axis_last  = 1'b0;
  endtask

  task automatic mon1(input int nexp);
    int got, t;
    bit fin;
    logic [199:0] e;
    bit el;
    got = 0; t = 0; fin = 0;
    while (!fin && t < 3000) begin
      @(negedge clk);
      t++;
      if (if1.m_win_valid) begin
        if (got == 0) check("k5_e44", if1.m_win_data[24*8 +: 8], 32);
        check("k5_sb_level", q1.size() > 0, 1);
        if (q1.size() > 0) begin
          e  = q1.pop_front();
          el = ql1.pop_front();
          check("k5_win_data", if1.m_win_data, e);
          check("k5_win_last", if1.m_win_last, el);
        end
        got++;
        fin = if1.m_win_last;
      end
    end
    check("k5_win_count", got, nexp);
    @(negedge clk);
    check("k5_done_hi", done1, 1);
    check("k5_last_err", lerr1, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    cw0 = '0; ch0 = '0; cs0 = 1'b0;
    cw1 = '0; ch1 = '0; cs1 = 1'b0;
    if0.s_axis_valid = 1'b0; if0.s_axis_data = '0;
    if0.s_axis_last = 1'b0; if0.m_win_ready = 1'b1;
    if1.s_axis_valid = 1'b0; if1.s_axis_data = '0;
    if1.s_axis_last = 1'b0; if1.m_win_ready = 1'b1;
    #12;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_cfg_err", cerr0, 0);
    check("rst_last_err", lerr0, 0);
    check("rst_s_ready", if0.s_axis_ready, 0);
    check("rst_m_valid", if0.m_win_valid, 0);
    check("rst_m_last", if0.m_win_last, 0);
    check("rst_m_data", if0.m_win_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run0(5, 4, 0, 0, 0);
    run0(5, 4, 1, 0, 0);

    cfg0(2, 10);
    check("bad_cfg_err", cerr0, 1);
    check("bad_cfg_busy", busy0, 0);
    run0(10, 10, 0, 0, 1);

    run0(5, 4, 0, 1, 0);

    for (int i = 0; i < 20; i++) img0[i] = 16'(i);
    cfg0(5, 4);
    drive0(5, 4, 14, 0);
    check("pre_rst_valid", if0.m_win_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_s_ready", if0.s_axis_ready, 0);
    check("mid_rst_m_valid", if0.m_win_valid, 0);
    check("mid_rst_m_last", if0.m_win_last, 0);
    check("mid_rst_m_data", if0.m_win_data, 0);
    check("mid_rst_done", done0, 0);
    q0.delete();
    ql0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run0(5, 4, 0, 0, 0);

    for (int i = 0; i < 42; i++) img1[i] = 8'(i % 256);
    cw1 = 5'd7;
    ch1 = 5'd6;
    cs1 = 1'b1;
    @(posedge clk);
    #1;
    cs1 = 1'b0;
    check("k5_busy", busy1, 1);
    fork
      drive1(7, 42);
      mon1(6);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_window_streamer.md
Name: conv_window_streamer

Overview:
- Parametrised sliding-window generator for the convolution datapath.
- Accepts a raster-order pixel stream on AXI4-Stream and holds the last K-1 image rows in line buffers.
- Emits one flat KxK window per valid (no-padding) output position to the multiplier array.
- Generalises the fixed 3x3 column-fill data path to runtime image size, any odd K, any pixel width, with frame/tlast checking and backpressure.

Parameters:
- DATA_W, 16, pixel width in bits (s_axis_data carries the pixel in bits [DATA_W-1:0]).
- K, 3, kernel edge; odd, 3..7.
- MAX_WIDTH, 1024, maximum image width; sets line buffer depth.
- DIM_W, 11, width of the size and counter fields; must satisfy 2^DIM_W > MAX_WIDTH.

Ports:
- axi_clk, in, 1, clock.
- axi_reset_n, in, 1, reset; asynchronous, active-low.
- cfg_width, in, DIM_W, image width in pixels; sampled on cfg_start.
- cfg_height, in, DIM_W, image height in rows; sampled on cfg_start.
- cfg_start, in, 1, single-cycle start pulse; honoured only in IDLE.
- busy, out, 1, high while in RUN.
- done, out, 1, one-cycle pulse when a frame completes.
- cfg_err, out, 1, sticky; set by an illegal config; cleared by the next legal cfg_start.
- last_err, out, 1, sticky; set by a tlast mismatch; cleared on cfg_start.
- s_axis_valid, in, 1, input pixel valid.
- s_axis_data, in, 32, input pixel; upper bits ignored.
- s_axis_last, in, 1, end of frame.
- s_axis_ready, out, 1, input ready.
- m_win_valid, out, 1, window valid.
- m_win_data, out, K*K*DATA_W, window; element (r,c) at [(r*K+c)*DATA_W +: DATA_W]; r=0 is the oldest row, c=0 the leftmost column.
- m_win_ready, in, 1, downstream ready.
- m_win_last, out, 1, marks the final window of the frame.

Behaviour:
- Reset (axi_reset_n low), asynchronous:
  - state IDLE; all counters 0.
  - busy, done, cfg_err, last_err, s_axis_ready, m_win_valid, m_win_last = 0; m_win_data = 0.
  - Line buffer contents are don't-care.
- State IDLE:
  - On cfg_start, check legality: K <= cfg_width <= MAX_WIDTH and cfg_height >= K.
  - Legal: latch width and height, clear both error flags, go to RUN next cycle.
  - Illegal: set cfg_err, stay in IDLE.
  - cfg_start outside IDLE is ignored.
- State RUN:
  - s_axis_ready = !m_win_valid || m_win_ready.
  - A pixel is accepted when s_axis_valid && s_axis_ready.
  - Each accepted pixel at (row, col) is written into the column shift window and the line buffers (one read/write per cycle per buffer).
  - col wraps at width-1; on wrap, row increments.
- Window output:
  - If row >= K-1 and col >= K-1, the accepted pixel completes a window.
  - m_win_valid rises the next cycle; latency is 1 cycle from acceptance.
  - The output register holds data stable until m_win_ready is high.
  - Warm-up pixels that complete no window are still accepted only when s_axis_ready is high.
- Window count per frame: (width-K+1)*(height-K+1).
  - m_win_last = 1 with the window completed by pixel (height-1, width-1).
- tlast checking:
  - s_axis_last on any other pixel, or missing on the final pixel, sets last_err.
  - The frame still ends by count; tlast never alters the counters.
- State DONE:
  - Entered on the handshake of the m_win_last window.
  - s_axis_ready = 0.
  - done pulses for 1 cycle, then return to IDLE.
- Simultaneous output consumption and new input acceptance in the same cycle is required (full throughput: 1 pixel per cycle).
- Arithmetic: pixels pass through untruncated at DATA_W bits; no arithmetic on data.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values; any partial window is discarded.

Test Plan:
- K=3, width=5, height=4, pixels 0..19, m_win_ready=1 -> 6 windows.
  - First window = {0,1,2,5,6,7,10,11,12}, valid 1 cycle after pixel 12 is accepted.
  - Last window = {7,8,9,12,13,14,17,18,19} with m_win_last=1.
  - done pulses 2 cycles later.
- Same frame with m_win_ready toggling 1,0,0,1 repeatedly -> same 6 windows in order, no loss or duplication.
  - m_win_data stable while stalled; s_axis_ready=0 whenever a window is stalled.
- cfg_width=2, cfg_height=10, cfg_start -> cfg_err=1, busy stays 0.
  - Then width=10, height=10, cfg_start -> cfg_err=0, busy=1, 64 windows with random pixels checked against a reference model.
- Frame of 5x4 with s_axis_last asserted on pixel 10 and not on pixel 19 -> last_err=1, still exactly 6 windows, done pulses.
- Reset asserted after pixel 13 of a 5x4 frame -> all outputs 0 immediately.
  - New 5x4 frame then produces the correct first window {0,1,2,5,6,7,10,11,12} from fresh data.
- K=5, DATA_W=8, width=7, height=6, pixels = index mod 256 -> 6 windows; first window element (4,4) = 32.
